sr_system_rx: RTL
=================

SR_SYSTEM_RX -- requirements
Module: sr_system_rx

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame (2..16).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 rts  input  1  request-to-send from upstream serial transmitter; high for the whole frame.
REQ-005 sclk  input  1  bit strobe from transmitter (its CLKOUT), one clk cycle wide per bit, synchronous to clk.
REQ-006 sdin  input  1  serial data, valid while sclk=1, LSB first.
REQ-007 rd  input  1  consumer read pulse; acknowledges dout.
REQ-008 ack  output  1  acknowledge to transmitter; frame accepted.
REQ-009 dout  output  WIDTH  last complete received word.
REQ-010 rxf  output  1  receive-full; dout holds unread word.
REQ-011 ferr  output  1  frame error; rts dropped mid-frame.
REQ-012 perr  output  1  parity error (see Configuration).

Function
REQ-013 FSM SHALL have states IDLE, ACK, SHIFT, LOAD.
REQ-014 IDLE: ack=0; go to ACK when rts=1 and rxf=0; with rxf=1 SHALL stay in IDLE, ack=0 (backpressure).
REQ-015 ACK: ack=1 for exactly one cycle; bit counter and shift register cleared; ferr and perr cleared; next state SHIFT.
REQ-016 SHIFT: on each edge with sclk=1, shift register SHALL take sdin into MSB and shift right (LSB-first assembly); counter +1.
REQ-017 SHIFT: when counter reaches NBITS (WIDTH, or WIDTH+1 with parity) on a sampling edge, next state LOAD.
REQ-018 SHIFT: sclk=0 cycles SHALL hold counter and shift register; no timeout.
REQ-019 SHIFT with rts=0 before NBITS bits: ferr<=1, state->IDLE, dout and rxf unchanged.
REQ-020 LOAD: dout<=data bits, rxf<=1, state->IDLE; dout/rxf visible on the second rising edge after the edge sampling the final bit.
REQ-021 rd=1 SHALL clear rxf, ferr and perr in any state except when LOAD sets rxf in the same cycle; set wins.
REQ-022 rd while rxf=0 SHALL have no effect.
REQ-023 sclk in IDLE, ACK or LOAD SHALL be ignored.
REQ-024 dout SHALL change only in LOAD.
REQ-025 rts still high on return to IDLE with rxf=1 SHALL not start a new frame until rd clears rxf.

Reset
REQ-026 rst=0 SHALL force state IDLE, counter 0, shift register 0, ack=0, dout=0, rxf=0, ferr=0, perr=0, immediately and asynchronously.
REQ-027 Reset mid-frame SHALL discard partial data; after release the block SHALL wait in IDLE for rts.

Configuration
REQ-028 Macro SR_SYSTEM_RX_PARITY_EN defined: frame = WIDTH data bits + 1 even-parity bit (NBITS=WIDTH+1); in LOAD perr<=1 if XOR of data and parity bit is 1; dout still loaded.
REQ-029 Macro undefined: NBITS=WIDTH, no parity logic, perr tied to 0.

Verification
REQ-030 Reset, rts=1, 8 strobes sdin=1,0,1,0,0,1,0,1 (no parity build) -> ack one-cycle pulse after rts, dout=0xA5, rxf=1, ferr=0.
REQ-031 rts=1, 3 strobes, rts=0 -> ferr=1, rxf=0, dout unchanged (0x00 after reset); next frame clears ferr in ACK.
REQ-032 rxf=1, rts=1 held 10 cycles -> ack=0 throughout; rd pulse -> rxf=0, ack pulse next-but-one cycle.
REQ-033 PARITY_EN: 0xA5 with parity bit 0 -> perr=0; same with parity bit 1 -> perr=1, dout=0xA5, rxf=1.
REQ-034 rst=0 after 5 bits of a frame -> all outputs 0 same cycle; after release, full frame 0x3C received correctly.
REQ-035 rd=1 on the LOAD cycle -> rxf=1 afterwards (set wins), dout=new word.

Source files
------------

// File: rtl/sr_system_rx.sv
// sr_system_rx: serial frame receiver for the upstream sr_system transmitter.
// Frame handshake: the transmitter raises rts and holds it for the whole frame;
// this block answers with a one-cycle ack, then samples sdin on every clk edge
// where sclk=1, LSB first. A complete word lands in dout with rxf=1 and is held
// (new frames are refused) until the consumer pulses rd while rxf=1.
// Optional feature macro: SR_SYSTEM_RX_PARITY_EN adds one trailing even-parity
// bit per frame and drives perr; without it perr is constant 0.
module sr_system_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rts,
    input  logic             sclk,
    input  logic             sdin,
    input  logic             rd,
    output logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             rxf,
    output logic             ferr,
    output logic             perr,
    output logic [1:0]       o_dbg_state
);

`ifdef SR_SYSTEM_RX_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS + 1);
    // Count value at which the sampling edge takes the final bit of the frame.
    localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACK   = 2'd1,
        S_SHIFT = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [NBITS-1:0] r_shift;
    logic             r_ack;
    logic [WIDTH-1:0] r_dout;
    logic             r_rxf;
    logic             r_ferr;
`ifdef SR_SYSTEM_RX_PARITY_EN
    logic             r_perr;
`endif

    // A read only acknowledges something when a word is actually pending.
    logic w_rd_clr;
    assign w_rd_clr = rd & r_rxf;

    // Frame FSM with registered outputs; state-specific updates are written
    // after the read-clear so that a LOAD in the same cycle wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_ack   <= 1'b0;
            r_dout  <= '0;
            r_rxf   <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef SR_SYSTEM_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            if (w_rd_clr) begin
                r_rxf  <= 1'b0;
                r_ferr <= 1'b0;
`ifdef SR_SYSTEM_RX_PARITY_EN
                r_perr <= 1'b0;
`endif
            end
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    // An unread word blocks the next frame (backpressure).
                    if (rts && !r_rxf) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_ferr  <= 1'b0;
`ifdef SR_SYSTEM_RX_PARITY_EN
                        r_perr  <= 1'b0;
`endif
                    end
                end
                S_ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!rts) begin
                        // Transmitter gave up mid-frame: drop the partial word.
                        r_ferr  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (sclk) begin
                        r_shift <= {sdin, r_shift[NBITS-1:1]};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_dout  <= r_shift[WIDTH-1:0];
                    r_rxf   <= 1'b1;
`ifdef SR_SYSTEM_RX_PARITY_EN
                    // Even parity: data plus parity bit must XOR to zero.
                    r_perr  <= ^r_shift;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack         = r_ack;
    assign dout        = r_dout;
    assign rxf         = r_rxf;
    assign ferr        = r_ferr;
`ifdef SR_SYSTEM_RX_PARITY_EN
    assign perr        = r_perr;
`else
    assign perr        = 1'b0;
`endif
    assign o_dbg_state = r_state;

endmodule
